// File: rtl/forth_mem_pkg.sv
// Shared defaults and port indices for the two-port memory arbiter.
package forth_mem_pkg;

   localparam int unsigned ADDR_W_DFLT   = 16;
   localparam int unsigned DATA_W_DFLT   = 16;
   localparam int unsigned LOCK_MAX_DFLT = 8;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_EXT = 1'b1
   } port_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick with last-winner register and an external
// priority override that favours port 1.
module arb_rr2
   import forth_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       hold_ext,
   output logic [1:0] gnt_c
);

   port_e last_win;

   // Grant is combinational and forced low while reset is held.
   always_comb begin
      gnt_c = 2'b00;
      if (rst_n) begin
         case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (hold_ext || last_win == PORT_CPU) ? 2'b10 : 2'b01;
            default: gnt_c = 2'b00;
         endcase
      end
   end

   // Reset to PORT_EXT so the CPU wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_win <= PORT_EXT;
      end else if (gnt_c[0]) begin
         last_win <= PORT_CPU;
      end else if (gnt_c[1]) begin
         last_win <= PORT_EXT;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU core (port 0) and loader/debug (port 1).
// Optional port-1 grant locking is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
   import forth_mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DFLT,
   parameter int unsigned DATA_W   = DATA_W_DFLT,
   parameter int unsigned LOCK_MAX = LOCK_MAX_DFLT
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_stall,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic              p1_lock,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] WData,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] RData
);

   logic [1:0] gnt_c;
   logic       hold_c;

   arb_rr2 u_arb (
      .clk      (Clk),
      .rst_n    (Rst),
      .req      ({p1_req, p0_req}),
      .hold_ext (hold_c),
      .gnt_c    (gnt_c)
   );

`ifdef MEM_ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   logic [CNT_W-1:0] lock_cnt;

   // Nonzero count means the latest grant was a locked port-1 beat.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         lock_cnt <= '0;
      end else if (gnt_c[1] && p1_lock) begin
         if (lock_cnt != CNT_W'(LOCK_MAX)) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
         end
      end else if (gnt_c[0] || gnt_c[1] || !p1_req) begin
         lock_cnt <= '0;
      end
   end

   assign hold_c = (lock_cnt != '0) && (lock_cnt < CNT_W'(LOCK_MAX));
`else
   logic unused_lock;

   assign unused_lock = ^{p1_lock, 32'(LOCK_MAX)};
   assign hold_c      = 1'b0;
`endif

   assign p0_gnt   = gnt_c[0];
   assign p1_gnt   = gnt_c[1];
   assign p0_stall = p0_req & ~gnt_c[0];

   // Memory side follows the granted port; idle bus is driven to zero.
   always_comb begin
      MemAddr  = '0;
      WData    = '0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (gnt_c[0]) begin
         MemAddr  = p0_addr;
         WData    = p0_wdata;
         MemRead  = ~p0_we;
         MemWrite = p0_we;
      end else if (gnt_c[1]) begin
         MemAddr  = p1_addr;
         WData    = p1_wdata;
         MemRead  = ~p1_we;
         MemWrite = p1_we;
      end
   end

   // Read responses: one-cycle rvalid pulse, rdata held between reads.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= gnt_c[0] & ~p0_we;
         p1_rvalid <= gnt_c[1] & ~p1_we;
         if (gnt_c[0] && !p0_we) begin
            p0_rdata <= RData;
         end
         if (gnt_c[1] && !p1_we) begin
            p1_rdata <= RData;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; memory model returns addr ^ 0xA5A5.
module tb_mem_arbiter;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        p0_req, p0_we;
   logic [15:0] p0_addr, p0_wdata;
   logic        p0_gnt, p0_stall, p0_rvalid;
   logic [15:0] p0_rdata;
   logic        p1_req, p1_we, p1_lock;
   logic [15:0] p1_addr, p1_wdata;
   logic        p1_gnt, p1_rvalid;
   logic [15:0] p1_rdata;
   logic [15:0] MemAddr, WData, RData;
   logic        MemRead, MemWrite;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(8)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_stall  (p0_stall),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_lock   (p1_lock),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .MemAddr   (MemAddr),
      .WData     (WData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .RData     (RData)
   );

   always #5 Clk = ~Clk;

   assign RData = MemAddr ^ 16'hA5A5;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_p0(input logic req, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata);
      p0_req   = req;
      p0_we    = we;
      p0_addr  = addr;
      p0_wdata = wdata;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic lock);
      p1_req   = req;
      p1_we    = we;
      p1_addr  = addr;
      p1_wdata = wdata;
      p1_lock  = lock;
   endtask

   task automatic idle();
      set_p0(1'b0, 1'b0, 16'h0, 16'h0);
      set_p1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      idle();
      step();
      step();
      Rst = 1'b1;
   endtask

   function automatic logic exp_p1_lock(input int i);
`ifdef MEM_ARB_LOCK_EN
      return (i >= 1 && i <= 8);
`else
      return (i % 2 == 1);
`endif
   endfunction

   logic [15:0] burst_addr [3];

   initial begin
      Rst = 1'b0;
      idle();
      step();
      step();

      // Requests during reset are not granted and produce nothing.
      set_p0(1'b1, 1'b0, 16'h0010, 16'h0);
      #1;
      check_eq("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check_eq("rst_memread", 32'(MemRead), 32'd0);
      check_eq("rst_memaddr", 32'(MemAddr), 32'h0);
      step();
      check_eq("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check_eq("rst_p0_rdata", 32'(p0_rdata), 32'h0);

      // Single p0 read right after reset release.
      Rst = 1'b1;
      #1;
      check_eq("rd0_p0_gnt", 32'(p0_gnt), 32'd1);
      check_eq("rd0_p1_gnt", 32'(p1_gnt), 32'd0);
      check_eq("rd0_memread", 32'(MemRead), 32'd1);
      check_eq("rd0_memwrite", 32'(MemWrite), 32'd0);
      check_eq("rd0_memaddr", 32'(MemAddr), 32'h0010);
      check_eq("rd0_stall", 32'(p0_stall), 32'd0);
      step();
      idle();
      #1;
      check_eq("rd0_rvalid", 32'(p0_rvalid), 32'd1);
      check_eq("rd0_rdata", 32'(p0_rdata), 32'hA5B5);
      check_eq("idle_memread", 32'(MemRead), 32'd0);
      check_eq("idle_memaddr", 32'(MemAddr), 32'h0);
      step();
      check_eq("rd0_rvalid_pulse", 32'(p0_rvalid), 32'd0);
      check_eq("rd0_rdata_hold", 32'(p0_rdata), 32'hA5B5);

      // Idle cycles must not disturb last winner (p0), so p1 wins contention.
      set_p0(1'b1, 1'b0, 16'h0040, 16'h0);
      set_p1(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0);
      #1;
      check_eq("lw_p1_gnt", 32'(p1_gnt), 32'd1);
      check_eq("lw_p0_gnt", 32'(p0_gnt), 32'd0);
      check_eq("lw_p0_stall", 32'(p0_stall), 32'd1);
      check_eq("lw_memaddr", 32'(MemAddr), 32'h0050);
      step();
      idle();
      #1;
      check_eq("lw_p1_rvalid", 32'(p1_rvalid), 32'd1);
      check_eq("lw_p1_rdata", 32'(p1_rdata), 32'hA5F5);
      check_eq("lw_p0_rvalid", 32'(p0_rvalid), 32'd0);

      // First cycle after reset: p0 read wins, p1 write follows.
      do_reset();
      set_p0(1'b1, 1'b0, 16'h0020, 16'h0);
      set_p1(1'b1, 1'b1, 16'h0030, 16'hBEEF, 1'b0);
      #1;
      check_eq("c1_p0_gnt", 32'(p0_gnt), 32'd1);
      check_eq("c1_p1_gnt", 32'(p1_gnt), 32'd0);
      check_eq("c1_p0_stall", 32'(p0_stall), 32'd0);
      check_eq("c1_memaddr", 32'(MemAddr), 32'h0020);
      step();
      set_p0(1'b0, 1'b0, 16'h0, 16'h0);
      #1;
      check_eq("c2_p1_gnt", 32'(p1_gnt), 32'd1);
      check_eq("c2_memwrite", 32'(MemWrite), 32'd1);
      check_eq("c2_memread", 32'(MemRead), 32'd0);
      check_eq("c2_memaddr", 32'(MemAddr), 32'h0030);
      check_eq("c2_wdata", 32'(WData), 32'hBEEF);
      check_eq("c2_p0_rvalid", 32'(p0_rvalid), 32'd1);
      check_eq("c2_p0_rdata", 32'(p0_rdata), 32'hA585);
      step();
      idle();
      #1;
      check_eq("c3_wr_no_rvalid", 32'(p1_rvalid), 32'd0);
      check_eq("c3_p0_rvalid", 32'(p0_rvalid), 32'd0);

      // Continuous contention alternates, starting with p0 (last winner p1).
      set_p0(1'b1, 1'b0, 16'h0100, 16'h0);
      set_p1(1'b1, 1'b0, 16'h0200, 16'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check_eq($sformatf("alt%0d_p0_gnt", i), 32'(p0_gnt), 32'(i % 2 == 0));
         check_eq($sformatf("alt%0d_p1_gnt", i), 32'(p1_gnt), 32'(i % 2 == 1));
         check_eq($sformatf("alt%0d_stall", i), 32'(p0_stall), 32'(i % 2 == 1));
         if (i > 0) begin
            check_eq($sformatf("alt%0d_p0_rvalid", i), 32'(p0_rvalid), 32'(i % 2 == 1));
            check_eq($sformatf("alt%0d_p1_rvalid", i), 32'(p1_rvalid), 32'(i % 2 == 0));
         end
         step();
      end
      idle();
      #1;
      check_eq("alt_end_p1_rvalid", 32'(p1_rvalid), 32'd1);
      check_eq("alt_end_p1_rdata", 32'(p1_rdata), 32'hA7A5);
      step();

      // Back-to-back p1 reads give back-to-back rvalid pulses.
      burst_addr[0] = 16'h0300;
      burst_addr[1] = 16'h0302;
      burst_addr[2] = 16'h0304;
      for (int k = 0; k < 3; k++) begin
         set_p1(1'b1, 1'b0, burst_addr[k], 16'h0, 1'b0);
         #1;
         check_eq($sformatf("b2b%0d_p1_gnt", k), 32'(p1_gnt), 32'd1);
         step();
         check_eq($sformatf("b2b%0d_rvalid", k), 32'(p1_rvalid), 32'd1);
         check_eq($sformatf("b2b%0d_rdata", k), 32'(p1_rdata),
                  32'(burst_addr[k] ^ 16'hA5A5));
      end
      idle();
      step();
      check_eq("b2b_rvalid_drop", 32'(p1_rvalid), 32'd0);

      // Locked port 1 against a persistent port 0.
      do_reset();
      set_p0(1'b1, 1'b0, 16'h0400, 16'h0);
      set_p1(1'b1, 1'b0, 16'h0500, 16'h0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         #1;
         check_eq($sformatf("lock%0d_p1_gnt", i), 32'(p1_gnt), 32'(exp_p1_lock(i)));
         check_eq($sformatf("lock%0d_p0_gnt", i), 32'(p0_gnt), 32'(!exp_p1_lock(i)));
         step();
      end

      // Reset during a p1 read grant suppresses it and restores p0 priority.
      do_reset();
      set_p0(1'b1, 1'b0, 16'h0060, 16'h0);
      step();
      Rst = 1'b0;
      set_p0(1'b0, 1'b0, 16'h0, 16'h0);
      set_p1(1'b1, 1'b0, 16'h0070, 16'h0, 1'b0);
      #1;
      check_eq("mr_p1_gnt", 32'(p1_gnt), 32'd0);
      check_eq("mr_memread", 32'(MemRead), 32'd0);
      check_eq("mr_memaddr", 32'(MemAddr), 32'h0);
      step();
      check_eq("mr_p1_rvalid", 32'(p1_rvalid), 32'd0);
      check_eq("mr_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check_eq("mr_p0_rdata", 32'(p0_rdata), 32'h0);
      check_eq("mr_p1_rdata", 32'(p1_rdata), 32'h0);
      Rst = 1'b1;
      set_p0(1'b1, 1'b0, 16'h0080, 16'h0);
      #1;
      check_eq("mr_post_p0_gnt", 32'(p0_gnt), 32'd1);
      check_eq("mr_post_p1_gnt", 32'(p1_gnt), 32'd0);
      step();
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter DATA_W, default 16, memory data width in bits.
REQ-003 Parameter LOCK_MAX, default 8, maximum consecutive locked port-1 beats.
REQ-004 Clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-low.
REQ-006 p0_req / p0_we  in  1 / 1  port 0 (CPU core) access request / write strobe.
REQ-007 p0_addr / p0_wdata  in  ADDR_W / DATA_W  port 0 address / write data.
REQ-008 p0_gnt  out  1  port 0 access performed this cycle.
REQ-009 p0_stall  out  1  equals p0_req & ~p0_gnt; the core holds PC and stack writes while high.
REQ-010 p0_rvalid / p0_rdata  out  1 / DATA_W  port 0 read response.
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: port 1 (loader/debug) equivalents of REQ-006..010.
REQ-012 p1_lock  in  1  port 1 requests grant retention for the next beat.
REQ-013 MemAddr / WData  out  ADDR_W / DATA_W  memory address / write data.
REQ-014 MemRead / MemWrite  out  1 / 1  memory strobes.
REQ-015 RData  in  DATA_W  memory read data, combinational from MemAddr.

Function
REQ-016 At most one port SHALL be granted per cycle; a grant is combinational in the cycle its req is high.
REQ-017 Granted port drives MemAddr/WData; MemWrite = we, MemRead = ~we; with no grant, both strobes are 0 and MemAddr/WData hold 0.
REQ-018 Requester SHALL hold req, we, addr and wdata stable until gnt; arbiter SHALL NOT assume this beyond the grant cycle.
REQ-019 Single requester: grant immediately. Both requesting: grant the port not granted most recently (last-winner register).
REQ-020 Last-winner register SHALL update only on a grant; idle cycles leave it unchanged.
REQ-021 Read grant at cycle N: rvalid = 1 and rdata = RData sampled at N, both registered, in cycle N+1 for one cycle only; rdata holds its value otherwise.
REQ-022 Write grants SHALL NOT raise rvalid.
REQ-023 Back-to-back grants to the same port SHALL yield back-to-back rvalid pulses.
REQ-024 Address is passed unchanged (byte addressing); no alignment check.

Reset
REQ-025 While Rst = 0: gnt, rvalid, MemRead, MemWrite = 0; rdata = 0; last-winner = port 1 (port 0 wins first contention); lock count = 0.
REQ-026 Reset asserted in a grant cycle SHALL suppress that access and its rvalid.

Configuration
REQ-027 Macro MEM_ARB_LOCK_EN: when defined, port 1 granted with p1_lock = 1 keeps priority next cycle over port 0; lock counter increments per locked grant.
REQ-028 With MEM_ARB_LOCK_EN, after LOCK_MAX consecutive locked grants, a requesting port 0 SHALL win the next contention; counter clears on p1_lock = 0, a port-0 grant, or an idle port 1.
REQ-029 Without MEM_ARB_LOCK_EN, p1_lock is ignored, no counter exists, pure round-robin applies.

Structure
REQ-030 Package forth_mem_pkg SHALL hold ADDR_W/DATA_W/LOCK_MAX defaults and the port-index enum (PORT_CPU = 0, PORT_EXT = 1).
REQ-031 Sub-module arb_rr2 SHALL implement the two-way round-robin pick plus last-winner register; datapath muxing and response registers stay in mem_arbiter.

Verification
REQ-032 After reset, p0 reads 0x0010 alone -> p0_gnt same cycle, MemRead = 1, MemAddr = 0x0010; next cycle p0_rvalid = 1 with memory content.
REQ-033 Both ports request in the first cycle after reset (p0 read 0x0020, p1 write 0x0030 = 0xBEEF) -> p0 granted, p0_stall = 0, p1 granted next cycle with MemWrite = 1, no p1_rvalid.
REQ-034 Both ports request continuously for 6 cycles -> grants alternate p0, p1, p0, p1, p0, p1; p0_stall high exactly on p1 cycles.
REQ-035 MEM_ARB_LOCK_EN, LOCK_MAX = 8, p1 locks while p0 requests -> 8 consecutive p1 grants, then p0 granted; without macro -> strict alternation.
REQ-036 Rst driven low in the cycle p1 is granted a read -> no p1_rvalid next cycle; all outputs 0; first contention after release goes to p0.
